// File: rtl/oled_spi_rx.sv
// SPI-target receiver for the OLED command/data link.
// Tagged bytes are queued in a FIFO read over a pipelined Wishbone port.
module oled_spi_rx #(
  parameter int LGFLEN = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  input  logic        i_sck,
  input  logic        i_cs_n,
  input  logic        i_mosi,
  input  logic        i_dbit,
  output logic        o_int
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FULL_LVL = (LGFLEN+1)'(DEPTH);
  localparam logic [LGFLEN:0] FILL_ONE = (LGFLEN+1)'(1);
  localparam logic [LGFLEN-1:0] PTR_ONE = LGFLEN'(1);

  // [0],[1] synchronize; [2] is the previous value for edge detection
  logic [2:0] sck_q, cs_q, mosi_q, dbit_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sck_q  <= 3'b111;
      cs_q   <= 3'b111;
      mosi_q <= 3'b000;
      dbit_q <= 3'b000;
    end else begin
      sck_q  <= {sck_q[1:0], i_sck};
      cs_q   <= {cs_q[1:0], i_cs_n};
      mosi_q <= {mosi_q[1:0], i_mosi};
      dbit_q <= {dbit_q[1:0], i_dbit};
    end
  end

  logic cs_n, sck_rise, cs_rise;
  assign cs_n     = cs_q[1];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];

  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic        push_pend;
  logic [8:0]  push_word;
  logic [15:0] bytecnt;
  logic        ferr_set;

  assign ferr_set = cs_rise & (bitcnt != 3'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bitcnt    <= 3'd0;
      shreg     <= 8'd0;
      push_pend <= 1'b0;
      push_word <= 9'd0;
      bytecnt   <= 16'd0;
    end else begin
      push_pend <= 1'b0;
      if (cs_n) begin
        bitcnt <= 3'd0;
        shreg  <= 8'd0;
      end else if (sck_rise) begin
        shreg  <= {shreg[6:0], mosi_q[1]};
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          push_pend <= 1'b1;
          push_word <= {dbit_q[1], shreg[6:0], mosi_q[1]};
          bytecnt   <= bytecnt + 16'd1;
        end
      end
    end
  end

  logic [8:0]        mem [DEPTH];
  logic [LGFLEN-1:0] wr_ptr, rd_ptr;
  logic [LGFLEN:0]   fill;
  logic              empty, full;
  logic              bus_wr, pop, flush, clr_ovfl, clr_ferr;
  logic              do_push, ovfl_set;
  logic              ovfl, ferr;

  assign empty    = (fill == '0);
  assign full     = (fill == FULL_LVL);
  assign bus_wr   = i_wb_cyc & i_wb_stb & i_wb_we & (i_wb_addr == 2'd0);
  assign pop      = i_wb_cyc & i_wb_stb & ~i_wb_we
                  & (i_wb_addr == 2'd1) & ~empty;
  assign flush    = bus_wr & i_wb_data[0];
  assign clr_ovfl = bus_wr & i_wb_data[31];
  assign clr_ferr = bus_wr & i_wb_data[30];
  assign do_push  = push_pend & ~flush & (~full | pop);
  assign ovfl_set = push_pend & ~flush & full & ~pop;

  always_ff @(posedge i_clk) begin
    if (do_push)
      mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   fill <= fill + FILL_ONE;
        2'b01:   fill <= fill - FILL_ONE;
        default: fill <= fill;
      endcase
    end
  end

  // a same-cycle set wins over a clear so no event is ever lost
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ovfl <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (ovfl_set)
        ovfl <= 1'b1;
      else if (clr_ovfl)
        ovfl <= 1'b0;
      if (ferr_set)
        ferr <= 1'b1;
      else if (clr_ferr)
        ferr <= 1'b0;
    end
  end

  logic [31:0] status, fifo_word;
  assign status = {ovfl, ferr, ~cs_n, 5'd0, 8'(fill), bytecnt};
  assign fifo_word = empty ? 32'h8000_0000
                           : {23'd0, mem[rd_ptr]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= 32'd0;
      o_int     <= 1'b0;
    end else begin
      o_wb_ack <= i_wb_stb;
      o_int    <= ~empty;
      if (i_wb_stb) begin
        case (i_wb_addr)
          2'd1, 2'd2: o_wb_data <= fifo_word;
          default:    o_wb_data <= status;
        endcase
      end
    end
  end

  assign o_wb_stall = 1'b0;

  logic unused_wdata;
  assign unused_wdata = ^i_wb_data[29:1];

endmodule

// File: tb/tb_oled_spi_rx.sv
// Self-checking bench for oled_spi_rx (FIFO depth 4).
// A byte-level queue model predicts FIFO, flags and counters.
module tb_oled_spi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic        ack, stall, irq;
  logic [31:0] rdata;
  logic        sck = 1'b1, cs_n = 1'b1, mosi = 1'b0, dbit = 1'b0;

  oled_spi_rx #(.LGFLEN(2)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdata),
    .i_sck(sck), .i_cs_n(cs_n), .i_mosi(mosi), .i_dbit(dbit),
    .o_int(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: bench did not finish, required completion");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  logic [8:0]  q[$];
  logic        m_ovfl = 1'b0, m_ferr = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  function automatic logic [31:0] exp_status();
    logic [7:0] f;
    f = 8'(q.size());
    return {m_ovfl, m_ferr, ~cs_n, 5'd0, f, m_cnt};
  endfunction

  function automatic logic [31:0] exp_head();
    if (q.size() == 0) return 32'h8000_0000;
    return {23'd0, q[0]};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovfl = 1'b0;
    m_ferr = 1'b0;
    m_cnt  = 16'd0;
  endtask

  task automatic spi_bits(input logic [7:0] v, input int n,
                          input logic d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mosi = v[7-i];
      dbit = d;
      sck  = 1'b0;
      wait_clks(5);
      sck = 1'b1;
      wait_clks(5);
    end
  endtask

  task automatic spi_byte(input logic [7:0] v, input logic d);
    spi_bits(v, 8, d);
    m_cnt = m_cnt + 16'd1;
    if (q.size() == 4) m_ovfl = 1'b1;
    else q.push_back({d, v});
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    wait_clks(5);
  endtask

  task automatic cs_high();
    wait_clks(5);
    cs_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic wb_read(input logic [1:0] a, input logic c,
                         output logic [31:0] d);
    @(negedge clk);
    cyc = c; stb = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    #1;
    d = rdata;
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL read_ack: got %b, required 1", ack);
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = v;
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL write_ack: got %b, required 1", ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; wdata = 32'd0;
  endtask

  task automatic check_status(input string nm);
    logic [31:0] e, d;
    e = exp_status();
    wb_read(2'd0, 1'b1, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s: status %h, required %h", nm, d, e);
    end
  endtask

  task automatic check_pop(input string nm);
    logic [31:0] e, d;
    e = exp_head();
    wb_read(2'd1, 1'b1, d);
    if (q.size() != 0) void'(q.pop_front());
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s: data %h, required %h", nm, d, e);
    end
  endtask

  task automatic check_int(input string nm);
    logic e;
    @(posedge clk);
    #1;
    e = (q.size() != 0);
    checks++;
    if (irq !== e) begin
      errors++;
      $display("FAIL %s: o_int %b, required %b", nm, irq, e);
    end
  endtask

  task automatic test_reset();
    wait_clks(3);
    checks++;
    if ({ack, rdata, irq, stall} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: %h, required 0",
               {ack, rdata, irq, stall});
    end
    @(negedge clk);
    rst = 1'b0;
    wait_clks(4);
    check_status("reset_status");
    check_pop("reset_empty");
  endtask

  task automatic test_single();
    cs_low();
    spi_byte(8'hAF, 1'b0);
    cs_high();
    check_status("single_fill");
    check_int("single_int_set");
    check_pop("single_data");
    check_int("single_int_clr");
    check_status("single_cnt");
  endtask

  task automatic test_cmd_data();
    cs_low();
    spi_byte(8'h81, 1'b0);
    spi_byte(8'h7F, 1'b1);
    cs_high();
    check_pop("cmd_byte");
    check_pop("data_byte");
    check_pop("cmd_data_empty");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n;
      logic [31:0] d, e;
      n = $urandom_range(1, 4);
      cs_low();
      for (int i = 0; i < n; i++)
        spi_byte(8'($urandom), 1'($urandom));
      cs_high();
      check_status("rand_status");
      // back-to-back DATA reads pop one entry per cycle
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd1;
      for (int i = 0; i <= n; i++) begin
        e = exp_head();
        if (q.size() != 0) void'(q.pop_front());
        @(posedge clk);
        #1;
        d = rdata;
        checks++;
        if (d !== e || ack !== 1'b1) begin
          errors++;
          $display("FAIL b2b_read[%0d]: data %h ack %b, required %h 1",
                   i, d, ack, e);
        end
      end
      cyc = 1'b0; stb = 1'b0;
    end
  endtask

  task automatic test_overflow();
    cs_low();
    for (int i = 1; i <= 5; i++)
      spi_byte(8'(i), 1'b0);
    cs_high();
    check_status("ovfl_status");
    for (int i = 0; i < 4; i++)
      check_pop("ovfl_data");
    wb_write(2'd0, 32'h8000_0000);
    m_ovfl = 1'b0;
    check_status("ovfl_clear");
  endtask

  task automatic test_frame_err();
    cs_low();
    spi_bits(8'hFF, 5, 1'b0);
    cs_high();
    m_ferr = 1'b1;
    cs_low();
    spi_byte(8'h3C, 1'b0);
    cs_high();
    check_status("ferr_status");
    check_pop("ferr_data");
    check_pop("ferr_empty");
    wb_write(2'd0, 32'h4000_0000);
    m_ferr = 1'b0;
    check_status("ferr_clear");
  endtask

  task automatic test_reset_mid();
    cs_low();
    spi_byte(8'hC3, 1'b1);
    spi_bits(8'hA0, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    wait_clks(2);
    checks++;
    if ({ack, rdata, irq} !== 34'd0) begin
      errors++;
      $display("FAIL midreset_outputs: %h, required 0",
               {ack, rdata, irq});
    end
    rst = 1'b0;
    wait_clks(6);
    spi_byte(8'h55, 1'b0);
    cs_high();
    check_status("midreset_status");
    check_pop("midreset_data");
  endtask

  task automatic test_peek_flush();
    logic [31:0] d, e;
    cs_low();
    for (int i = 0; i < 3; i++)
      spi_byte(8'($urandom), 1'($urandom));
    cs_high();
    for (int i = 0; i < 2; i++) begin
      e = exp_head();
      wb_read(2'd2, 1'b1, d);
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL peek[%0d]: data %h, required %h", i, d, e);
      end
    end
    check_status("peek_fill");
    e = exp_head();
    wb_read(2'd1, 1'b0, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL nocyc_read: data %h, required %h", d, e);
    end
    check_status("nocyc_nopop");
    wb_write(2'd0, 32'h0000_0001);
    q.delete();
    check_int("flush_int");
    check_status("flush_fill");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_cmd_data();
    test_random();
    test_overflow();
    test_frame_err();
    test_reset_mid();
    test_peek_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
